// File: rtl/x_skew_buffer.sv
// Multi-lane X-edge staging buffer: random-access load per lane, lockstep drain,
// and a per-lane delay line so lane i reaches the array i cycles after lane 0.
module x_skew_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int LANES  = 8,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    WR_EN,
  input  logic [LANE_W-1:0]       WR_LANE,
  input  logic [IDX_W-1:0]        WR_IDX,
  input  logic [DATA_W-1:0]       DIN,
  input  logic                    VALID_IN,
  input  logic                    START,
  input  logic [LEN_W-1:0]        LEN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [LANES*DATA_W-1:0] DOUT,
  output logic [LANES-1:0]        VALID_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [LANE_W-1:0]   r_flush_cnt;
  logic                r_done;
  logic                w_done_next;
  logic                w_start_ok;
  logic                w_wr_ok;
  logic                w_last_rd;
  logic                w_flush_end;
  logic [LEN_W-1:0]    w_len_clamped;
  logic [IDX_W-1:0]    w_rd_idx;

  assign w_start_ok    = (r_state == S_IDLE) && START && (LEN != '0);
  assign w_wr_ok       = (r_state == S_IDLE) && WR_EN &&
                         (32'(WR_IDX) < DEPTH) && (32'(WR_LANE) < LANES);
  assign w_len_clamped = (32'(LEN) > DEPTH) ? LEN_W'(DEPTH) : LEN;
  assign w_last_rd     = (r_cnt == r_len - LEN_W'(1));
  assign w_flush_end   = (r_flush_cnt == LANE_W'(LANES - 2));
  assign w_rd_idx      = r_cnt[IDX_W-1:0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else if (EN) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_rd) w_state_next = (LANES == 1) ? S_IDLE : S_FLUSH;
      S_FLUSH: if (w_flush_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY        = (r_state != S_IDLE);
    DONE        = r_done;
    w_done_next = ((r_state == S_DRAIN) && w_last_rd && (LANES == 1)) ||
                  ((r_state == S_FLUSH) && w_flush_end);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else if (EN) begin
      r_done <= w_done_next;
      if (w_start_ok) begin
        r_len <= w_len_clamped;
        r_cnt <= '0;
      end
      if (r_state == S_DRAIN) begin
        r_cnt <= r_cnt + LEN_W'(1);
        if (w_last_rd) r_flush_cnt <= '0;
      end
      if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + LANE_W'(1);
    end
  end

  // Each lane: storage of {valid, data} cleared on read, then a gi+1 deep delay line.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W:0] r_mem  [DEPTH];
      logic [DATA_W:0] r_skew [0:gi];
      logic [DATA_W:0] w_stage0;

      assign w_stage0 = (r_state == S_DRAIN) ? r_mem[w_rd_idx] : '0;

      always_ff @(posedge CLK) begin
        if (!RST) begin
          for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
          for (int s = 0; s <= gi; s++) r_skew[s] <= '0;
        end else if (EN) begin
          if (w_wr_ok && (WR_LANE == LANE_W'(gi))) begin
            r_mem[WR_IDX] <= {VALID_IN, DIN};
          end else if (r_state == S_DRAIN) begin
            r_mem[w_rd_idx] <= '0;
          end
          r_skew[0] <= w_stage0;
          for (int s = 1; s <= gi; s++) r_skew[s] <= r_skew[s-1];
        end
      end

      assign DOUT[gi*DATA_W +: DATA_W] = r_skew[gi][DATA_W-1:0];
      assign VALID_OUT[gi]             = r_skew[gi][DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_x_skew_buffer.sv
// Scoreboard bench for x_skew_buffer: expected per-cycle output frames are queued
// when a drain starts and compared as the DUT emits them.
module tb_x_skew_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int LANES  = 8;
  localparam int IDX_W  = 5;
  localparam int LANE_W = 3;
  localparam int LEN_W  = 6;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    wr_en;
  logic [LANE_W-1:0]       wr_lane;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_W-1:0]       din;
  logic                    valid_in;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    busy;
  logic                    done;
  logic [LANES*DATA_W-1:0] dout;
  logic [LANES-1:0]        valid_out;

  typedef struct packed {
    logic [LANES*DATA_W-1:0] dout;
    logic [LANES-1:0]        vld;
    logic                    done;
    logic                    busy;
  } exp_t;

  exp_t            q[$];
  logic [DATA_W:0] sh [LANES][DEPTH];
  int              n_checks;
  int              n_fail;

  x_skew_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .CLK(clk), .RST(rst), .EN(en), .WR_EN(wr_en), .WR_LANE(wr_lane),
    .WR_IDX(wr_idx), .DIN(din), .VALID_IN(valid_in), .START(start), .LEN(len),
    .BUSY(busy), .DONE(done), .DOUT(dout), .VALID_OUT(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < DEPTH; j++) sh[i][j] = '0;
  endtask

  task automatic wr(input int lane, input int idx, input logic [DATA_W-1:0] d, input logic v);
    wr_en    = 1'b1;
    wr_lane  = lane[LANE_W-1:0];
    wr_idx   = idx[IDX_W-1:0];
    din      = d;
    valid_in = v;
    step();
    wr_en = 1'b0;
    sh[lane][idx] = {v, d};
  endtask

  task automatic load_basic();
    for (int l = 0; l < LANES; l++)
      for (int j = 0; j < 4; j++) wr(l, j, 8'(l * 16 + j), 1'b1);
  endtask

  // Queue one expected frame per enabled edge after START (k+1 .. k+len+LANES).
  task automatic push_drain(input int dlen);
    exp_t e;
    int   j;
    for (int t = 1; t <= dlen + LANES; t++) begin
      e.dout = '0;
      e.vld  = '0;
      for (int i = 0; i < LANES; i++) begin
        j = t - 1 - i;
        if (j >= 0 && j < dlen) begin
          e.dout[i*DATA_W +: DATA_W] = sh[i][j][DATA_W-1:0];
          e.vld[i] = sh[i][j][DATA_W];
        end
      end
      e.done = (t == dlen + LANES - 1);
      e.busy = (t < dlen + LANES - 1);
      q.push_back(e);
    end
    for (int i = 0; i < LANES; i++)
      for (int jj = 0; jj < dlen; jj++) sh[i][jj] = '0;
  endtask

  task automatic do_start(input int l, input int eff);
    start = 1'b1;
    len   = l[LEN_W-1:0];
    step();
    start = 1'b0;
    push_drain(eff);
    $display("drain start len=%0d effective=%0d at %0t", l, eff, $time);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    step(); step();
    n_checks++;
    if ({dout, valid_out, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial dout=%h vld=%b busy=%b done=%b expected all 0", dout, valid_out, busy, done);
    end
    rst = 1'b1;
    step();
    for (int n = 0; n < 20; n++) wr($urandom_range(0, LANES-1), $urandom_range(0, DEPTH-1), 8'($urandom), 1'b1);
    rst = 1'b0;
    step(); step();
    clear_shadow();
    n_checks++;
    if ({dout, valid_out, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_after_writes dout=%h vld=%b busy=%b done=%b expected all 0", dout, valid_out, busy, done);
    end
    rst = 1'b1;
    step();
    do_start(32, 32);
    for (int t = 1; q.size() > 0; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL reset_drain t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
  endtask

  task automatic test_basic_skew();
    exp_t e;
    load_basic();
    do_start(4, 4);
    for (int t = 1; q.size() > 0; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL basic_skew t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    e = '0;
    load_basic();
    do_start(4, 4);
    for (int c = 1; q.size() > 0; c++) begin
      en = !(c >= 3 && c <= 5);
      step();
      if (en) e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL stall c=%0d en=%b dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 c, en, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_ignored();
    exp_t e;
    load_basic();
    do_start(4, 4);
    for (int t = 1; q.size() > 0; t++) begin
      if (t == 2) begin
        wr_en = 1'b1; wr_lane = '0; wr_idx = '0; din = 8'hFF; valid_in = 1'b1;
        start = 1'b1; len = 6'd4;
      end
      step();
      wr_en = 1'b0;
      start = 1'b0;
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL ignored_first t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
    do_start(4, 4);
    for (int t = 1; q.size() > 0; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL ignored_second t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
  endtask

  task automatic test_len_bounds();
    exp_t e;
    start = 1'b1;
    len   = '0;
    step();
    start = 1'b0;
    $display("drain start len=0 (expected ignored) at %0t", $time);
    for (int t = 1; t <= 2; t++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL len_zero t=%0d busy=%b done=%b expected 0 0", t, busy, done);
      end
      step();
    end
    for (int l = 0; l < LANES; l++) wr(l, DEPTH - 1 - l, 8'($urandom), 1'b1);
    wr(LANES - 1, DEPTH - 1, 8'hA5, 1'b1);
    wr(3, 10, 8'h3C, 1'b0);
    do_start(40, 32);
    for (int t = 1; q.size() > 0; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL len_clamp t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    load_basic();
    do_start(4, 4);
    for (int t = 1; t <= 5; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL abort_pre t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    q.delete();
    clear_shadow();
    n_checks++;
    if ({dout, valid_out, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset dout=%h vld=%b busy=%b done=%b expected all 0", dout, valid_out, busy, done);
    end
    for (int t = 1; t <= 6; t++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done t=%0d done=%b busy=%b expected 0 0", t, done, busy);
      end
    end
    do_start(4, 4);
    for (int t = 1; q.size() > 0; t++) begin
      step();
      e = q.pop_front();
      n_checks++;
      if ({dout, valid_out, done, busy} !== {e.dout, e.vld, e.done, e.busy}) begin
        n_fail++;
        $display("FAIL abort_cleared t=%0d dout=%h vld=%b done=%b busy=%b expected dout=%h vld=%b done=%b busy=%b",
                 t, dout, valid_out, done, busy, e.dout, e.vld, e.done, e.busy);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b1;
    wr_en    = 1'b0;
    wr_lane  = '0;
    wr_idx   = '0;
    din      = '0;
    valid_in = 1'b0;
    start    = 1'b0;
    len      = '0;
    clear_shadow();
    @(negedge clk);
    test_reset();
    test_basic_skew();
    test_stall();
    test_ignored();
    test_len_bounds();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
